// File: rtl/alu.sv
// 32-bit registered ALU for the execute stage: 18 MIPS-style operations with
// N/Z/C/V status flags, all outputs registered one clock after the inputs.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ans,
  output logic        carry,
  output logic        neg,
  output logic        zero,
  output logic        over,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b
);

  // No handshake: valid is implied on every edge and the unit is always ready,
  // so one operation is accepted per cycle and its result appears one edge later.

  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_OR   = 5'd1;
  localparam logic [4:0] OP_XOR  = 5'd2;
  localparam logic [4:0] OP_NOR  = 5'd3;
  localparam logic [4:0] OP_ADDU = 5'd4;
  localparam logic [4:0] OP_SUBU = 5'd5;
  localparam logic [4:0] OP_ADD  = 5'd6;
  localparam logic [4:0] OP_SUB  = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SLLV = 5'd9;
  localparam logic [4:0] OP_SRL  = 5'd10;
  localparam logic [4:0] OP_SRLV = 5'd11;
  localparam logic [4:0] OP_SLT  = 5'd12;
  localparam logic [4:0] OP_SLTU = 5'd13;
  localparam logic [4:0] OP_CLO  = 5'd14;
  localparam logic [4:0] OP_CLZ  = 5'd15;
  localparam logic [4:0] OP_SRA  = 5'd16;
  localparam logic [4:0] OP_SRAV = 5'd17;

  logic [32:0] add_full;
  logic [32:0] sub_full;
  logic [4:0]  shamt;
  logic [31:0] r;
  logic        c;
  logic        v;

  // Subtraction as a + ~b + 1 so the carry out reads as "no borrow".
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + 33'd1;
  assign shamt    = b[4:0];

  function automatic logic [5:0] lead_count(input logic [31:0] v_in, input logic bit_val);
    logic [5:0] n;
    logic       run;
    n   = 6'd0;
    run = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      if (run && (v_in[i] == bit_val)) n = n + 6'd1;
      else                             run = 1'b0;
    end
    return n;
  endfunction

  always_comb begin
    r = 32'd0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADDU: begin
        r = add_full[31:0];
        c = add_full[32];
      end
      OP_SUBU: begin
        r = sub_full[31:0];
        c = sub_full[32];
      end
      OP_ADD: begin
        r = add_full[31:0];
        c = add_full[32];
        v = (a[31] == b[31]) && (add_full[31] != a[31]);
      end
      OP_SUB: begin
        r = sub_full[31:0];
        c = sub_full[32];
        v = (a[31] != b[31]) && (sub_full[31] != a[31]);
      end
      OP_SLL, OP_SLLV: r = a << shamt;
      OP_SRL, OP_SRLV: r = a >> shamt;
      OP_SRA, OP_SRAV: r = $signed(a) >>> shamt;
      OP_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU: r = {31'd0, (a < b)};
      OP_CLO:  r = {26'd0, lead_count(a, 1'b1)};
      OP_CLZ:  r = {26'd0, lead_count(a, 1'b0)};
      default: r = 32'd0;
    endcase
  end

  // Reset wins over the in-flight result; Z is cleared too, not derived from ans.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ans   <= 32'd0;
      carry <= 1'b0;
      neg   <= 1'b0;
      zero  <= 1'b0;
      over  <= 1'b0;
    end else begin
      ans   <= r;
      carry <= c;
      neg   <= r[31];
      zero  <= (r == 32'd0);
      over  <= v;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases with hand-derived results plus
// randomized operations scored against an arithmetic reference model.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  op = 5'd4;
  logic [31:0] a = 32'd7;
  logic [31:0] b = 32'd3;
  logic [31:0] ans;
  logic        carry, neg, zero, over;

  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];

  alu dut (
    .clk(clk), .rst_n(rst_n), .ans(ans), .carry(carry), .neg(neg),
    .zero(zero), .over(over), .op(op), .a(a), .b(b)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Reference model: {ans, C, N, Z, V} from plain wide arithmetic.
  function automatic logic [35:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    longint unsigned ux, uy, usum;
    longint sx, sy, ssum;
    logic [31:0] res;
    logic cf, vf;
    int n;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    res = 32'd0; cf = 1'b0; vf = 1'b0;
    if (o == 5'd4 || o == 5'd6) begin
      usum = ux + uy;
      res  = usum[31:0];
      cf   = (usum >= 64'h1_0000_0000);
      ssum = sx + sy;
      if (o == 5'd6) vf = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    end else if (o == 5'd5 || o == 5'd7) begin
      usum = ux - uy;
      res  = usum[31:0];
      cf   = (ux >= uy);
      ssum = sx - sy;
      if (o == 5'd7) vf = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    end else begin
      case (o)
        5'd0: res = x & y;
        5'd1: res = x | y;
        5'd2: res = x ^ y;
        5'd3: res = ~(x | y);
        5'd8, 5'd9:   res = x << (y % 32);
        5'd10, 5'd11: res = x >> (y % 32);
        5'd16, 5'd17: begin
          ssum = sx >>> (y % 32);
          res  = ssum[31:0];
        end
        5'd12: res = (sx < sy) ? 32'd1 : 32'd0;
        5'd13: res = (ux < uy) ? 32'd1 : 32'd0;
        5'd14, 5'd15: begin
          n = 0;
          while (n < 32 && x[31-n] == (o == 5'd14)) n++;
          res = n;
        end
        default: res = 32'd0;
      endcase
    end
    return {res, cf, res[31], (res == 32'd0), vf};
  endfunction

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Driver: apply one operation mid-cycle, then score the registered result.
  task automatic drive(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [35:0] expv;
    @(negedge clk);
    op = o; a = x; b = y;
    exp_q.push_back(rst_n ? model(o, x, y) : 36'd0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=queue_empty expected=entry", tag);
    end else begin
      expv = exp_q.pop_front();
      check(tag, {ans, carry, neg, zero, over}, expv);
    end
  endtask

  // Directed step: scoreboard check plus a literal result/flags check.
  task automatic dir(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp_ans, input logic [3:0] exp_cnzv);
    drive(tag, o, x, y);
    check({tag, "_lit"}, {ans, carry, neg, zero, over}, {exp_ans, exp_cnzv});
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [0:7];
    corners[0] = 32'h0000_0000; corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000; corners[3] = 32'h7FFF_FFFF;
    corners[4] = 32'h0000_0001; corners[5] = 32'h0000_001F;
    corners[6] = 32'hFFFF_0000; corners[7] = 32'h0000_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    // Reset held for two edges with an ADDU on the inputs
    rst_n = 1'b0;
    dir("rst0", 5'd4, 32'd7, 32'd3, 32'd0, 4'b0000);
    dir("rst1", 5'd4, 32'd7, 32'd3, 32'd0, 4'b0000);
    rst_n = 1'b1;
    dir("rel", 5'd4, 32'd7, 32'd3, 32'h0000_000A, 4'b0000);

    dir("and0",  5'd0, 32'd0, 32'd0, 32'd0, 4'b0010);
    dir("nor0",  5'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 4'b0100);
    dir("addu",  5'd4, 32'd7, 32'd3, 32'd10, 4'b0000);
    dir("add",   5'd6, 32'd9, 32'd1, 32'd10, 4'b0000);
    dir("addu_c", 5'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b1010);
    dir("subu",  5'd5, 32'd9, 32'd10, 32'hFFFF_FFFF, 4'b0100);
    dir("sub_v", 5'd7, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b1001);
    dir("add_v", 5'd6, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0101);
    dir("sll",   5'd8, 32'd1, 32'd1, 32'd2, 4'b0000);
    dir("srlv",  5'd11, 32'd1, 32'd2, 32'd0, 4'b0010);
    dir("srav",  5'd17, 32'h100, 32'd1, 32'h80, 4'b0000);
    dir("sra",   5'd16, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'b0100);
    dir("srl_hi", 5'd10, 32'h8000_0000, 32'h24, 32'h0800_0000, 4'b0000);
    dir("slt",   5'd12, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000);
    dir("sltu",  5'd13, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0010);
    dir("slt_eq", 5'd12, 32'd1, 32'd1, 32'd0, 4'b0010);
    dir("clz",   5'd15, 32'd1, 32'd0, 32'd31, 4'b0000);
    dir("clo32", 5'd14, 32'hFFFF_FFFF, 32'd0, 32'd32, 4'b0000);
    dir("clo0",  5'd14, 32'd1, 32'd0, 32'd0, 4'b0010);
    dir("clz32", 5'd15, 32'd0, 32'd0, 32'd32, 4'b0000);
    dir("rsvd",  5'd20, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 4'b0010);

    // Reset asserted mid-stream discards the in-flight result
    rst_n = 1'b0;
    dir("mid_rst", 5'd3, 32'd0, 32'd0, 32'd0, 4'b0000);
    rst_n = 1'b1;

    // Back-to-back: a different opcode on each of 18 consecutive edges
    for (int i = 0; i < 18; i++) drive($sformatf("b2b_op%0d", i), 5'(i), pick(), pick());

    // Randomized operations over the full opcode space
    for (int i = 0; i < 400; i++) begin
      drive($sformatf("rnd%0d", i), 5'($urandom_range(0, 31)), pick(), pick());
    end

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
